mz_host: RTL and testbench

Command-side initiator for the memory-zeroing block. Accepts single commands (write, read, zero-range) on a valid/ready request port. Sequences them onto the zeroer's ld_low/ld_high/addr/din/write/zero pins and tracks its busy flag. Returns one response per command, so upstream logic never handles the zeroer's pin-level protocol.

---
 rtl/mz_host.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_mz_host.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mz_host.sv
// mz_host: command-side initiator for the memory-zeroing block.
//
// Accepts one command at a time (write, read, zero-range) on a valid/ready
// port, sequences it onto the zeroer's pins and returns one response pulse.
//
// Optional feature: define MZ_HOST_VERIFY_EN to read back the zeroed range
// after each zero command. Any non-zero word is reported with rsp_err=1 and the
// first failing address in rsp_data. The default build leaves out the
// read-back state and its counter.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     request handshake
//   cmd_op                  00 write, 01 read, 10 zero range, 11 reserved
//   cmd_lo/cmd_hi/cmd_data  command fields, captured on accept
//   rsp_valid/rsp_data/rsp_err  one-cycle response; data and err hold between responses
//   ld_low/ld_high/addr/din/write/zero  registered zeroer controls
//   dout/busy               zeroer read data and busy flag
module mz_host #(
    parameter int ADDRWIDTH = 6,
    parameter int DATAWIDTH = 8,
    parameter int RD_LAT    = 1,
    parameter int BUSY_WIN  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ADDRWIDTH-1:0] cmd_lo,
    input  logic [ADDRWIDTH-1:0] cmd_hi,
    input  logic [DATAWIDTH-1:0] cmd_data,
    output logic                 rsp_valid,
    output logic [DATAWIDTH-1:0] rsp_data,
    output logic                 rsp_err,
    output logic                 ld_low,
    output logic                 ld_high,
    output logic [ADDRWIDTH-1:0] addr,
    output logic [DATAWIDTH-1:0] din,
    output logic                 write,
    output logic                 zero,
    input  logic [DATAWIDTH-1:0] dout,
    input  logic                 busy
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_WR    = 4'd1;
    localparam logic [3:0] S_RD    = 4'd2;
    localparam logic [3:0] S_RDW   = 4'd3;
    localparam logic [3:0] S_LDLO  = 4'd4;
    localparam logic [3:0] S_LDHI  = 4'd5;
    localparam logic [3:0] S_ZGO   = 4'd6;
    localparam logic [3:0] S_ZRISE = 4'd7;
    localparam logic [3:0] S_ZFALL = 4'd8;
`ifdef MZ_HOST_VERIFY_EN
    localparam logic [3:0] S_VFY   = 4'd9;
`endif
    localparam logic [3:0] S_RESP  = 4'd10;

    // Shared wait counter for read latency, busy-rise window and read-back.
    localparam int CW = $clog2(RD_LAT + BUSY_WIN + 1) + 1;

    logic [3:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [ADDRWIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [DATAWIDTH-1:0] din_q, din_d;
    logic [DATAWIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 ld_low_q, ld_low_d, ld_high_q, ld_high_d;
    logic                 write_q, write_d, zero_q, zero_d;
    logic                 zdone;
`ifdef MZ_HOST_VERIFY_EN
    // One bit wider than an address so a 0..max range cannot wrap early.
    logic [ADDRWIDTH:0]   vaddr_q, vaddr_d;
    logic                 vfail_q, vfail_d;
    logic [ADDRWIDTH-1:0] vfail_addr_q, vfail_addr_d;
`endif

    assign cmd_ready = (state_q == S_IDLE) && !busy && !reset;

    // Every output register is loaded together with the state it belongs to,
    // so a strobe is high for exactly the one cycle spent in that state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        addr_d      = addr_q;
        din_d       = din_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = 1'b0;
        ld_low_d    = 1'b0;
        ld_high_d   = 1'b0;
        write_d     = 1'b0;
        zero_d      = 1'b0;
        zdone       = 1'b0;
`ifdef MZ_HOST_VERIFY_EN
        vaddr_d      = vaddr_q;
        vfail_d      = vfail_q;
        vfail_addr_d = vfail_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    lo_d = cmd_lo;
                    hi_d = cmd_hi;
                    case (cmd_op)
                        2'b00: begin
                            state_d = S_WR;
                            addr_d  = cmd_lo;
                            din_d   = cmd_data;
                            write_d = 1'b1;
                        end
                        2'b01: begin
                            state_d = S_RD;
                            addr_d  = cmd_lo;
                        end
                        2'b10: begin
                            // An inverted range still spends one cycle in
                            // LDLO, but with the load strobe suppressed.
                            state_d = S_LDLO;
                            if (cmd_lo <= cmd_hi) begin
                                addr_d   = cmd_lo;
                                ld_low_d = 1'b1;
                            end
                        end
                        default: begin
                            state_d     = S_RESP;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                            rsp_data_d  = '0;
                        end
                    endcase
                end
            end
            S_WR: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = '0;
            end
            S_RD: begin
                state_d = S_RDW;
                cnt_d   = '0;
            end
            S_RDW: begin
                // RD is the first cycle addr is valid; dout is sampled in
                // the cycle RD_LAT cycles later.
                if (cnt_q == CW'(RD_LAT - 1)) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = dout;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LDLO: begin
                if (lo_q > hi_q) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                end else begin
                    state_d   = S_LDHI;
                    addr_d    = hi_q;
                    ld_high_d = 1'b1;
                end
            end
            S_LDHI: begin
                state_d = S_ZGO;
                zero_d  = 1'b1;
            end
            S_ZGO: begin
                state_d = S_ZRISE;
                cnt_d   = '0;
            end
            S_ZRISE: begin
                // A very short range can finish before busy is ever seen.
                if (busy) begin
                    state_d = S_ZFALL;
                end else if (cnt_q == CW'(BUSY_WIN - 1)) begin
                    zdone = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ZFALL: begin
                if (!busy) begin
                    zdone = 1'b1;
                end
            end
`ifdef MZ_HOST_VERIFY_EN
            S_VFY: begin
                if (cnt_q == CW'(RD_LAT)) begin
                    if ((dout != '0) && !vfail_q) begin
                        vfail_d      = 1'b1;
                        vfail_addr_d = vaddr_q[ADDRWIDTH-1:0];
                    end
                    if (vaddr_q == {1'b0, hi_q}) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = vfail_d;
                        rsp_data_d  = vfail_d ? DATAWIDTH'(vfail_addr_d) : '0;
                    end else begin
                        vaddr_d = vaddr_q + (ADDRWIDTH + 1)'(1);
                        addr_d  = vaddr_d[ADDRWIDTH-1:0];
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (zdone) begin
`ifdef MZ_HOST_VERIFY_EN
            state_d      = S_VFY;
            addr_d       = lo_q;
            cnt_d        = '0;
            vaddr_d      = {1'b0, lo_q};
            vfail_d      = 1'b0;
            vfail_addr_d = '0;
`else
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = '0;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            addr_q       <= '0;
            din_q        <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            ld_low_q     <= 1'b0;
            ld_high_q    <= 1'b0;
            write_q      <= 1'b0;
            zero_q       <= 1'b0;
`ifdef MZ_HOST_VERIFY_EN
            vaddr_q      <= '0;
            vfail_q      <= 1'b0;
            vfail_addr_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            rsp_valid_q  <= rsp_valid_d;
            ld_low_q     <= ld_low_d;
            ld_high_q    <= ld_high_d;
            write_q      <= write_d;
            zero_q       <= zero_d;
`ifdef MZ_HOST_VERIFY_EN
            vaddr_q      <= vaddr_d;
            vfail_q      <= vfail_d;
            vfail_addr_q <= vfail_addr_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign ld_low    = ld_low_q;
    assign ld_high   = ld_high_q;
    assign addr      = addr_q;
    assign din       = din_q;
    assign write     = write_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_mz_host.sv
// Testbench for mz_host: behavioural zeroer memory plus a response scoreboard
// whose expectations are computed from a shadow memory at command issue.
module tb_mz_host;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int RD_LAT = 1;
    localparam int BUSY_WIN = 4;
    localparam int FAULT_ADDR = 17;

    logic clock, reset;
    logic cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [AW-1:0] cmd_lo, cmd_hi;
    logic [DW-1:0] cmd_data;
    logic rsp_valid, rsp_err;
    logic [DW-1:0] rsp_data;
    logic ld_low, ld_high, write, zero;
    logic [AW-1:0] addr;
    logic [DW-1:0] din, dout;
    logic busy;

    mz_host #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .RD_LAT(RD_LAT), .BUSY_WIN(BUSY_WIN)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ld_low(ld_low), .ld_high(ld_high), .addr(addr), .din(din),
        .write(write), .zero(zero), .dout(dout), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h required=0x%0h", name, got, exp);
        end
    endtask

    // ---------------- zeroer model (environment) ----------------
    logic [DW-1:0] mem [64];
    logic [AW-1:0] zlo, zhi;
    logic [AW:0]   zptr;
    logic          zbusy;
    logic          busy_force;
    logic          fault_en;
    logic [DW-1:0] rp [RD_LAT];
    logic [DW-1:0] rdv;

    assign busy = zbusy | busy_force;
    assign rdv  = (fault_en && addr == AW'(FAULT_ADDR)) ? 8'h01 : mem[addr];
    assign dout = rp[RD_LAT-1];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            zbusy <= 1'b0;
            zptr  <= '0;
            for (int i = 0; i < RD_LAT; i++) rp[i] <= '0;
        end else begin
            if (write) mem[addr] <= din;
            if (ld_low) zlo <= addr;
            if (ld_high) zhi <= addr;
            if (zero) begin
                zbusy <= 1'b1;
                zptr  <= {1'b0, zlo};
            end else if (zbusy) begin
                mem[zptr[AW-1:0]] <= '0;
                if (zptr[AW-1:0] == zhi) zbusy <= 1'b0;
                else zptr <= zptr + 1;
            end
            rp[0] <= rdv;
            for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
        end
    end

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] lo, hi;
        logic [DW-1:0] wdata;
        logic [DW-1:0] data;
        logic          err;
        int            n_wr;
        int            n_zr;
    } exp_t;

    exp_t exp_q[$];
    logic [DW-1:0] shadow [64];

    function automatic void model_push(input logic [1:0] op, input logic [AW-1:0] lo,
                                       input logic [AW-1:0] hi, input logic [DW-1:0] d);
        exp_t e;
        e.op = op; e.lo = lo; e.hi = hi; e.wdata = d;
        e.data = '0; e.err = 1'b0; e.n_wr = 0; e.n_zr = 0;
        case (op)
            2'b00: begin shadow[lo] = d; e.n_wr = 1; end
            2'b01: e.data = (fault_en && int'(lo) == FAULT_ADDR) ? 8'h01 : shadow[lo];
            2'b10: begin
                if (lo > hi) e.err = 1'b1;
                else begin
                    e.n_zr = 1;
                    for (int a = int'(lo); a <= int'(hi); a++) shadow[a] = '0;
`ifdef MZ_HOST_VERIFY_EN
                    if (fault_en && FAULT_ADDR >= int'(lo) && FAULT_ADDR <= int'(hi)) begin
                        e.err = 1'b1;
                        e.data = DW'(FAULT_ADDR);
                    end
`endif
                end
            end
            default: e.err = 1'b1;
        endcase
        exp_q.push_back(e);
    endfunction

    // ---------------- compare process ----------------
    int n_wr = 0, n_ll = 0, n_lh = 0, n_z = 0, strobe_total = 0;
    int rsp_cnt = 0, last_rsp_cyc = 0;
    logic [DW-1:0] last_data;
    logic last_err;
    int t_ll = 0, t_lh = 0, t_z = 0, t_fall = 0;
    logic busy_prev = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            n_wr = 0; n_ll = 0; n_lh = 0; n_z = 0;
            busy_prev = 1'b0;
        end else begin
            if (busy_prev && !busy) t_fall = cyc;
            busy_prev = busy;
            if (write || ld_low || ld_high || zero) begin
                strobe_total++;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL strobe_orphan got wr=%0d ll=%0d lh=%0d z=%0d required none", write, ld_low, ld_high, zero);
                end else begin
                    if (write) begin
                        n_wr++;
                        chk("wr_addr", 32'(addr), 32'(exp_q[0].lo));
                        chk("wr_din", 32'(din), 32'(exp_q[0].wdata));
                    end
                    if (ld_low) begin n_ll++; t_ll = cyc; chk("ldlo_addr", 32'(addr), 32'(exp_q[0].lo)); end
                    if (ld_high) begin n_lh++; t_lh = cyc; chk("ldhi_addr", 32'(addr), 32'(exp_q[0].hi)); end
                    if (zero) begin n_z++; t_z = cyc; end
                end
            end
            if (rsp_valid) begin
                rsp_cnt++;
                last_rsp_cyc = cyc;
                last_data = rsp_data;
                last_err = rsp_err;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rsp_unexpected got data=0x%0h err=%0d required none", rsp_data, rsp_err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("[TB] rsp op=%0d lo=%0d hi=%0d data=0x%02h err=%0d", e.op, e.lo, e.hi, rsp_data, rsp_err);
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("n_write", 32'(n_wr), 32'(e.n_wr));
                    chk("n_ldlo", 32'(n_ll), 32'(e.n_zr));
                    chk("n_ldhi", 32'(n_lh), 32'(e.n_zr));
                    chk("n_zero", 32'(n_z), 32'(e.n_zr));
                end
                n_wr = 0; n_ll = 0; n_lh = 0; n_z = 0;
            end
        end
    end

    // ---------------- driver ----------------
    int acc_cyc = 0;

    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] lo,
                           input logic [AW-1:0] hi, input logic [DW-1:0] d);
        int n;
        int start;
        start = rsp_cnt;
        model_push(op, lo, hi, d);
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = op; cmd_lo = lo; cmd_hi = hi; cmd_data = d;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            exp_q.delete();
            return;
        end
        acc_cyc = cyc;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (rsp_cnt == start && n < 2000) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (rsp_cnt == start) begin
            chk("rsp_timeout", 32'(rsp_cnt), 32'(start + 1));
            exp_q.delete();
        end
    endtask

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog got=timeout required=finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int n;
        int rel_cyc;
        int saved;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_lo = '0; cmd_hi = '0; cmd_data = '0;
        busy_force = 1'b0; fault_en = 1'b0;
        for (int i = 0; i < 64; i++) begin mem[i] = '0; shadow[i] = '0; end

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_outs", {rsp_valid, rsp_err, ld_low, ld_high, write, zero}, 0);
        chk("rst_vals", {addr, din, rsp_data}, 0);
        @(negedge clock) reset = 1'b0;
        @(negedge clock);
        chk("idle_ready", 32'(cmd_ready), 1);

        // 1: write then read
        run_cmd(2'b00, 6'd3, 6'd0, 8'h5A);
        chk("t1_wr_lat", 32'(last_rsp_cyc - acc_cyc), 2);
        chk("t1_wr_err", 32'(last_err), 0);
        run_cmd(2'b01, 6'd3, 6'd0, 8'h00);
        chk("t1_rd_data", 32'(last_data), 32'h5A);
        chk("t1_rd_lat", 32'(last_rsp_cyc - acc_cyc), 32'(RD_LAT + 2));

        // 2: fill 1..6, zero 2..5, read back
        for (int a = 1; a <= 6; a++) run_cmd(2'b00, AW'(a), 6'd0, 8'hFF);
        run_cmd(2'b10, 6'd2, 6'd5, 8'h00);
        chk("t2_ll_after_acc", 32'(t_ll - acc_cyc), 1);
        chk("t2_lh_seq", 32'(t_lh - t_ll), 1);
        chk("t2_z_seq", 32'(t_z - t_lh), 1);
`ifdef MZ_HOST_VERIFY_EN
        chk("t2_rsp_after_fall", 32'(last_rsp_cyc - t_fall), 32'(1 + 4 * (RD_LAT + 1)));
`else
        chk("t2_rsp_after_fall", 32'(last_rsp_cyc - t_fall), 1);
`endif
        chk("t2_zero_err", 32'(last_err), 0);
        for (int a = 1; a <= 6; a++) begin
            run_cmd(2'b01, AW'(a), 6'd0, 8'h00);
            chk("t2_readback", 32'(last_data), (a >= 2 && a <= 5) ? 32'h00 : 32'hFF);
        end

        // 3: inverted range
        saved = strobe_total;
        run_cmd(2'b10, 6'd9, 6'd4, 8'h00);
        chk("t3_lat", 32'(last_rsp_cyc - acc_cyc), 2);
        chk("t3_err", 32'(last_err), 1);
        chk("t3_no_strobes", 32'(strobe_total - saved), 0);

        // 4: reserved op, then busy held in IDLE
        saved = strobe_total;
        run_cmd(2'b11, 6'd1, 6'd2, 8'h33);
        chk("t4_err", 32'(last_err), 1);
        chk("t4_data", 32'(last_data), 0);
        chk("t4_no_strobes", 32'(strobe_total - saved), 0);
        busy_force = 1'b1;
        rel_cyc = -1;
        fork
            run_cmd(2'b01, 6'd6, 6'd0, 8'h00);
            begin
                repeat (4) begin
                    @(negedge clock);
                    #1 chk("t4_ready_busy", 32'(cmd_ready), 0);
                end
                @(posedge clock);
                #1 busy_force = 1'b0;
                rel_cyc = cyc;
            end
        join
        chk("t4_accept_cyc", 32'(acc_cyc), 32'(rel_cyc));
        chk("t4_rd_data", 32'(last_data), 32'hFF);

        // 5: reset during ZFALL
        model_push(2'b10, 6'd10, 6'd50, 8'h00);
        saved = rsp_cnt;
        @(negedge clock);
        chk("t5_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_lo = 6'd10; cmd_hi = 6'd50;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (!busy && n < 50) begin @(negedge clock); n++; end
        chk("t5_busy_rose", 32'(busy), 1);
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_outs", {rsp_valid, rsp_err, ld_low, ld_high, write, zero, cmd_ready}, 0);
        chk("t5_rst_vals", {addr, din, rsp_data}, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        repeat (5) @(negedge clock);
        chk("t5_no_rsp", 32'(rsp_cnt), 32'(saved));
        run_cmd(2'b01, 6'd6, 6'd0, 8'h00);
        chk("t5_read_after", 32'(last_data), 32'hFF);

        // 6: full range zero with a faulty word at FAULT_ADDR
        fault_en = 1'b1;
        run_cmd(2'b10, 6'd0, 6'd63, 8'h00);
        fault_en = 1'b0;
`ifdef MZ_HOST_VERIFY_EN
        chk("t6_err", 32'(last_err), 1);
        chk("t6_data", 32'(last_data), 17);
`else
        chk("t6_err", 32'(last_err), 0);
        chk("t6_data", 32'(last_data), 0);
`endif
        run_cmd(2'b01, 6'd63, 6'd0, 8'h00);
        chk("t6_read63", 32'(last_data), 0);

        repeat (3) @(negedge clock);
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
